// File: rtl/assert_change_multi.sv
// assert_change_multi
//   Multi-channel "expression must change within a window" checker.
//   A per-channel start_event opens a window of num_cks cycles. The first
//   change of the channel's test_expr slice inside the window closes it and
//   is reported as early (before cycle min_cks) or as a pass. If nothing
//   changes by cycle num_cks, the window times out and fire_late is raised.
//   A start that arrives while the window is open is handled according to
//   action_on_new_start.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   reset          : synchronous, active-high
//   start_event    : per-channel window trigger
//   test_expr      : channel c in bits [c*width +: width]
//   window         : per-channel window-open flag
//   fire_late      : one-cycle pulse, no change by the end of the window
//   fire_early     : one-cycle pulse, change before cycle min_cks
//   fire_new_start : one-cycle pulse, start while open (error mode only)
//   cover_pass     : one-cycle pulse, legal change observed
//   config_error   : constant 1 when a parameter is out of its legal range
//
// Per-channel states
//   state | meaning
//   IDLE  | window = 0, waiting for start_event
//   OPEN  | window = 1, k = elapsed window cycles (1..num_cks)

module assert_change_multi #(
    parameter int width               = 8,
    parameter int num_ch              = 2,
    parameter int num_cks             = 4,
    parameter int min_cks             = 1,
    parameter int action_on_new_start = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [num_ch-1:0]       start_event,
    input  logic [num_ch*width-1:0] test_expr,
    output logic [num_ch-1:0]       window,
    output logic [num_ch-1:0]       fire_late,
    output logic [num_ch-1:0]       fire_early,
    output logic [num_ch-1:0]       fire_new_start,
    output logic [num_ch-1:0]       cover_pass,
    output logic                    config_error
);

    localparam int KW = (num_cks < 1) ? 1 : $clog2(num_cks + 1);
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic [KW-1:0] K_MIN = KW'(min_cks);
    localparam logic [KW-1:0] K_MAX = KW'(num_cks);

    localparam bit CFG_BAD = (width < 1) || (num_ch < 1) ||
                             (num_cks < 1) || (num_cks > 255) ||
                             (min_cks < 1) || (min_cks > num_cks) ||
                             (action_on_new_start < 0) ||
                             (action_on_new_start > 2);

    logic [num_ch-1:0]             win_q, win_d;
    logic [num_ch-1:0][KW-1:0]     k_q, k_d;
    logic [num_ch-1:0][width-1:0]  prev_q;
    logic [num_ch-1:0]             late_q, late_d;
    logic [num_ch-1:0]             early_q, early_d;
    logic [num_ch-1:0]             ns_q, ns_d;
    logic [num_ch-1:0]             pass_q, pass_d;
    logic [num_ch-1:0]             change;

    // State register. prev tracks test_expr even during reset so the first
    // window after reset never sees a stale value as a change.
    always_ff @(posedge clk) begin
        prev_q <= test_expr;
        if (reset) begin
            win_q   <= '0;
            k_q     <= '0;
            late_q  <= '0;
            early_q <= '0;
            ns_q    <= '0;
            pass_q  <= '0;
        end else begin
            win_q   <= win_d;
            k_q     <= k_d;
            late_q  <= late_d;
            early_q <= early_d;
            ns_q    <= ns_d;
            pass_q  <= pass_d;
        end
    end

    // Next state. Priority inside OPEN: change, then mode-1 restart, then
    // timeout, then mode-2 new-start report. A window that is closing (by
    // change or timeout) never also reports a new start, which keeps the
    // per-channel pulses mutually exclusive.
    always_comb begin
        win_d   = win_q;
        k_d     = k_q;
        late_d  = '0;
        early_d = '0;
        ns_d    = '0;
        pass_d  = '0;
        change  = '0;
        for (int c = 0; c < num_ch; c++) begin
            change[c] = win_q[c] && (test_expr[c*width +: width] != prev_q[c]);
            if (!win_q[c]) begin
                if (start_event[c]) begin
                    win_d[c] = 1'b1;
                    k_d[c]   = K_ONE;
                end
            end else if (change[c]) begin
                if (k_q[c] < K_MIN) begin
                    early_d[c] = 1'b1;
                end else begin
                    pass_d[c] = 1'b1;
                end
                win_d[c] = 1'b0;
                k_d[c]   = '0;
            end else if (start_event[c] && (action_on_new_start == 1)) begin
                k_d[c] = K_ONE;
            end else if (k_q[c] >= K_MAX) begin
                late_d[c] = 1'b1;
                win_d[c]  = 1'b0;
                k_d[c]    = '0;
            end else begin
                k_d[c] = k_q[c] + K_ONE;
                if (start_event[c] && (action_on_new_start == 2)) begin
                    ns_d[c] = 1'b1;
                end
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        window         = win_q;
        fire_late      = late_q;
        fire_early     = early_q;
        fire_new_start = ns_q;
        cover_pass     = pass_q;
    end

    assign config_error = CFG_BAD;

endmodule

// File: tb/tb_assert_change_multi.sv
module tb_assert_change_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start_event;
    logic [15:0] test_expr;

    logic [1:0] win [4];
    logic [1:0] late [4];
    logic [1:0] early [4];
    logic [1:0] ns [4];
    logic [1:0] pass [4];
    logic       cfg [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assert_change_multi #(.width(8), .num_ch(2), .num_cks(4), .min_cks(2), .action_on_new_start(0)) u0 (
        .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr),
        .window(win[0]), .fire_late(late[0]), .fire_early(early[0]),
        .fire_new_start(ns[0]), .cover_pass(pass[0]), .config_error(cfg[0]));
    assert_change_multi #(.width(8), .num_ch(2), .num_cks(4), .min_cks(2), .action_on_new_start(1)) u1 (
        .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr),
        .window(win[1]), .fire_late(late[1]), .fire_early(early[1]),
        .fire_new_start(ns[1]), .cover_pass(pass[1]), .config_error(cfg[1]));
    assert_change_multi #(.width(8), .num_ch(2), .num_cks(4), .min_cks(2), .action_on_new_start(2)) u2 (
        .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr),
        .window(win[2]), .fire_late(late[2]), .fire_early(early[2]),
        .fire_new_start(ns[2]), .cover_pass(pass[2]), .config_error(cfg[2]));
    assert_change_multi #(.width(8), .num_ch(2), .num_cks(4), .min_cks(5), .action_on_new_start(0)) u3 (
        .clk(clk), .reset(reset), .start_event(start_event), .test_expr(test_expr),
        .window(win[3]), .fire_late(late[3]), .fire_early(early[3]),
        .fire_new_start(ns[3]), .cover_pass(pass[3]), .config_error(cfg[3]));

    typedef struct {
        logic        rst;
        logic [1:0]  st;
        logic [15:0] x;
        logic [1:0]  win;
        logic [1:0]  late;
        logic [1:0]  early;
        logic [1:0]  pass;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic rst, logic [1:0] st, logic [15:0] x,
                                logic [1:0] w, logic [1:0] l, logic [1:0] e, logic [1:0] p);
        vec_t v;
        v.rst = rst; v.st = st; v.x = x; v.win = w; v.late = l; v.early = e; v.pass = p;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] st, input logic [15:0] x);
        reset       = rst;
        start_event = st;
        test_expr   = x;
        @(posedge clk);
        #1;
    endtask

    // Reference model: windows tracked by the cycle index at which they
    // (re)opened; elapsed count is the difference to the current cycle.
    int         n_cyc = 0;
    bit         m_open [3][2];
    int         m_t0 [3][2];
    logic [7:0] m_last [2];
    logic [1:0] e_win [3], e_late [3], e_early [3], e_ns [3], e_pass [3];

    function automatic void model_step(logic rst, logic [1:0] st, logic [15:0] x);
        n_cyc++;
        for (int m = 0; m < 3; m++) begin
            e_late[m] = '0; e_early[m] = '0; e_ns[m] = '0; e_pass[m] = '0;
            for (int c = 0; c < 2; c++) begin
                logic [7:0] xs;
                int         el;
                xs = x[c*8 +: 8];
                el = n_cyc - m_t0[m][c];
                if (rst) begin
                    m_open[m][c] = 0;
                end else if (!m_open[m][c]) begin
                    if (st[c]) begin
                        m_open[m][c] = 1;
                        m_t0[m][c]   = n_cyc;
                    end
                end else if (xs != m_last[c]) begin
                    if (el < 2) e_early[m][c] = 1'b1;
                    else        e_pass[m][c]  = 1'b1;
                    m_open[m][c] = 0;
                end else if (st[c] && m == 1) begin
                    m_t0[m][c] = n_cyc;
                end else if (el == 4) begin
                    e_late[m][c] = 1'b1;
                    m_open[m][c] = 0;
                end else if (st[c] && m == 2) begin
                    e_ns[m][c] = 1'b1;
                end
                e_win[m][c] = m_open[m][c];
            end
        end
        for (int c = 0; c < 2; c++) m_last[c] = x[c*8 +: 8];
    endfunction

    initial begin
        logic [15:0] rx;
        reset = 1'b1; start_event = '0; test_expr = '0;
        #1;
        chk("cfg_err_bad", {31'd0, cfg[3]}, 32'd1);
        chk("cfg_err_ok",  {31'd0, cfg[0]}, 32'd0);

        //   rst st     x         win    late   early  pass
        add(1, 2'b00, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 16'h0011, 2'b01, 2'b00, 2'b00, 2'b00);  // open ch0
        add(0, 2'b00, 16'h0011, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0011, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0011, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0011, 2'b00, 2'b01, 2'b00, 2'b00);  // timeout
        add(0, 2'b00, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 16'h0011, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0022, 2'b00, 2'b00, 2'b01, 2'b00);  // change at k=1
        add(0, 2'b00, 16'h0022, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 16'h0022, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0022, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0022, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b01);  // change at k=3
        add(0, 2'b00, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b10, 16'h0011, 2'b10, 2'b00, 2'b00, 2'b00);  // open ch1
        add(0, 2'b00, 16'h0011, 2'b10, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h3311, 2'b00, 2'b00, 2'b00, 2'b10);  // change at k=min
        add(0, 2'b00, 16'h3311, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 16'h3311, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h3311, 2'b01, 2'b00, 2'b00, 2'b00);
        add(1, 2'b00, 16'h3355, 2'b00, 2'b00, 2'b00, 2'b00);  // reset mid-window
        add(0, 2'b01, 16'h3355, 2'b01, 2'b00, 2'b00, 2'b00);
        add(0, 2'b00, 16'h3355, 2'b01, 2'b00, 2'b00, 2'b00);

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].st, tv[i].x);
            chk($sformatf("vec%0d", i),
                {22'd0, win[0], late[0], early[0], ns[0], pass[0]},
                {22'd0, tv[i].win, tv[i].late, tv[i].early, 2'b00, tv[i].pass});
        end

        // restart mode: second start at k=4 suppresses the timeout
        drive(1, 2'b00, 16'h0011);
        drive(0, 2'b01, 16'h0011);
        repeat (3) drive(0, 2'b00, 16'h0011);
        drive(0, 2'b01, 16'h0011);
        chk("m1_restart", {28'd0, win[1], late[1]}, {28'd0, 2'b01, 2'b00});
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b00, 16'h0011);
            chk($sformatf("m1_hold%0d", i), {28'd0, win[1], late[1]}, {28'd0, 2'b01, 2'b00});
        end
        drive(0, 2'b00, 16'h0011);
        chk("m1_late", {28'd0, win[1], late[1]}, {28'd0, 2'b00, 2'b01});

        // error mode: new start reported, window continues
        drive(1, 2'b00, 16'h0011);
        drive(0, 2'b01, 16'h0011);
        drive(0, 2'b00, 16'h0011);
        drive(0, 2'b01, 16'h0011);
        chk("m2_ns", {28'd0, win[2], ns[2]}, {28'd0, 2'b01, 2'b01});
        drive(0, 2'b00, 16'h0011);
        chk("m2_ns_gone", {28'd0, win[2], ns[2]}, {28'd0, 2'b01, 2'b00});
        drive(0, 2'b00, 16'h0011);
        chk("m2_late", {28'd0, win[2], late[2]}, {28'd0, 2'b00, 2'b01});
        drive(0, 2'b01, 16'h0011);
        drive(0, 2'b00, 16'h0011);
        drive(0, 2'b00, 16'h0011);
        drive(0, 2'b01, 16'h0022);
        chk("m2_change_prio", {26'd0, win[2], ns[2], pass[2]}, {26'd0, 2'b00, 2'b00, 2'b01});

        // randomized run against the reference model
        rx = 16'h0000;
        model_step(1'b1, 2'b00, rx);
        drive(1'b1, 2'b00, rx);
        for (int i = 0; i < 600; i++) begin
            logic       r;
            logic [1:0] s;
            r = ($urandom_range(0, 39) == 0);
            s[0] = ($urandom_range(0, 3) == 0);
            s[1] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) rx[7:0]  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rx[15:8] = 8'($urandom);
            model_step(r, s, rx);
            drive(r, s, rx);
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("rand_m%0d_c%0d", m, i),
                    {22'd0, win[m], late[m], early[m], ns[m], pass[m]},
                    {22'd0, e_win[m], e_late[m], e_early[m], e_ns[m], e_pass[m]});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
